// File: rtl/npc_unit_pkg.sv
// Shared MIPS opcode/funct/regimm-rt codes, reset vector and next-PC types for npc_unit.
// Decode helper classifies a D-stage instruction's control-flow kind.
package npc_unit_pkg;

  localparam logic [31:0] NPC_RESET_PC = 32'h0000_3000;

  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_REGIMM  = 6'b000001;
  localparam logic [5:0] OP_J       = 6'b000010;
  localparam logic [5:0] OP_JAL     = 6'b000011;
  localparam logic [5:0] OP_BEQ     = 6'b000100;

  localparam logic [4:0] RT_BLTZ    = 5'b00000;
  localparam logic [4:0] RT_BGEZAL  = 5'b10001;

  localparam logic [5:0] FN_JR      = 6'b001000;
  localparam logic [5:0] FN_JALR    = 6'b001001;

  typedef enum logic {
    RUN   = 1'b0,
    FAULT = 1'b1
  } npc_state_t;

  typedef enum logic [1:0] {
    KIND_SEQ = 2'd0,
    KIND_BR  = 2'd1,
    KIND_JMP = 2'd2,
    KIND_REG = 2'd3
  } npc_kind_t;

  function automatic npc_kind_t decode_kind(input logic [31:0] instr);
    npc_kind_t kind;
    kind = KIND_SEQ;
    case (instr[31:26])
      OP_BEQ:     kind = KIND_BR;
      OP_REGIMM:  if (instr[20:16] == RT_BGEZAL || instr[20:16] == RT_BLTZ) kind = KIND_BR;
      OP_J,
      OP_JAL:     kind = KIND_JMP;
      OP_SPECIAL: if (instr[5:0] == FN_JR || instr[5:0] == FN_JALR) kind = KIND_REG;
      default:    kind = KIND_SEQ;
    endcase
    return kind;
  endfunction

endpackage

// File: rtl/npc_target.sv
// Combinational next-PC target select from the D-stage instruction, plus redirect and misalign flags.
// Zero latency; no state, so no backpressure of its own.
module npc_target
  import npc_unit_pkg::*;
(
  input  logic [31:0] instr,
  input  logic [31:0] d_pc,
  input  logic [31:0] f_pc,
  input  logic [31:0] rs_data,
  input  logic        cmp_taken,
  output logic [31:0] target,
  output logic        redirect,
  output logic        is_cf,
  output logic        misalign
);

  npc_kind_t   kind;
  logic [31:0] br_off;
  logic [31:0] br_tgt;
  logic [31:0] jmp_tgt;
  logic [31:0] seq_pc;

  assign kind    = decode_kind(instr);
  assign br_off  = {{14{instr[15]}}, instr[15:0], 2'b00};
  assign br_tgt  = d_pc + 32'd4 + br_off;
  assign jmp_tgt = {d_pc[31:28], instr[25:0], 2'b00};
  assign seq_pc  = f_pc + 32'd4;

  always_comb begin
    target   = seq_pc;
    redirect = 1'b0;
    case (kind)
      KIND_BR: begin
        if (cmp_taken) begin
          target   = br_tgt;
          redirect = 1'b1;
        end
      end
      KIND_JMP: begin
        target   = jmp_tgt;
        redirect = 1'b1;
      end
      KIND_REG: begin
        target   = rs_data;
        redirect = 1'b1;
      end
      default: begin
        target   = seq_pc;
        redirect = 1'b0;
      end
    endcase
  end

  assign is_cf    = (kind != KIND_SEQ);
  assign misalign = (target[1:0] != 2'b00);

endmodule

// File: rtl/npc_unit.sv
// Fetch next-PC unit: holds F_PC, follows D-stage branch/jump redirects, traps misaligned targets.
// New F_PC one edge after D decision; stall freezes F_PC. Optional counters under NPC_STATS_EN.
module npc_unit
  import npc_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = NPC_RESET_PC
`ifdef NPC_STATS_EN
  , parameter int CNT_W = 32
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic [31:0]      D_Instr,
  input  logic [31:0]      D_PC,
  input  logic             cmp_taken,
  input  logic [31:0]      D_rs_data,
  output logic [31:0]      F_PC,
  output logic [31:0]      D_link_pc,
  output logic             redirect,
  output logic             pc_fault
`ifdef NPC_STATS_EN
  , output logic [CNT_W-1:0] br_count
  , output logic [CNT_W-1:0] tk_count
`endif
);

  npc_state_t  state_q, state_d;
  logic [31:0] pc_d;
  logic [31:0] tgt;
  logic        tgt_redirect;
  logic        tgt_is_cf;
  logic        tgt_misalign;
  logic        advance;

  npc_target u_target (
    .instr     (D_Instr),
    .d_pc      (D_PC),
    .f_pc      (F_PC),
    .rs_data   (D_rs_data),
    .cmp_taken (cmp_taken),
    .target    (tgt),
    .redirect  (tgt_redirect),
    .is_cf     (tgt_is_cf),
    .misalign  (tgt_misalign)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
      F_PC    <= RESET_PC;
    end else begin
      state_q <= state_d;
      F_PC    <= pc_d;
    end
  end

  // FAULT is terminal until reset: PC frozen and no redirect advertised.
  always_comb begin
    state_d  = state_q;
    pc_d     = F_PC;
    redirect = 1'b0;
    advance  = 1'b0;
    case (state_q)
      RUN: begin
        redirect = tgt_redirect;
        if (!stall) begin
          advance = 1'b1;
          if (tgt_misalign) state_d = FAULT;
          else              pc_d    = tgt;
        end
      end
      FAULT: begin
        state_d = FAULT;
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  assign pc_fault  = (state_q == FAULT);
  assign D_link_pc = D_PC + 32'd8;

`ifdef NPC_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      br_count <= '0;
      tk_count <= '0;
    end else if (advance) begin
      if (tgt_is_cf)    br_count <= br_count + 1'b1;
      if (tgt_redirect) tk_count <= tk_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_npc_unit.sv
// Randomized self-checking bench for npc_unit against a behavioural next-PC model.
// Directed literal checks pin the model; build with NPC_STATS_EN to cover the counters.
`timescale 1ns/1ps
module tb_npc_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0;
  logic        cmp_taken = 1'b0;
  logic [31:0] D_Instr = 32'd0;
  logic [31:0] D_PC = 32'h0000_2ffc;
  logic [31:0] D_rs_data = 32'd0;
  logic [31:0] F_PC;
  logic [31:0] D_link_pc;
  logic        redirect;
  logic        pc_fault;
`ifdef NPC_STATS_EN
  logic [31:0] br_count;
  logic [31:0] tk_count;
`endif

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  npc_unit dut (
    .clk       (clk),
    .reset     (reset),
    .stall     (stall),
    .D_Instr   (D_Instr),
    .D_PC      (D_PC),
    .cmp_taken (cmp_taken),
    .D_rs_data (D_rs_data),
    .F_PC      (F_PC),
    .D_link_pc (D_link_pc),
    .redirect  (redirect),
    .pc_fault  (pc_fault)
`ifdef NPC_STATS_EN
    , .br_count (br_count)
    , .tk_count (tk_count)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference rules: where the fetch goes next given the D-stage instruction.
  function automatic void ref_next(input logic [31:0] instr, input logic [31:0] dpc,
                                   input logic [31:0] fpc, input logic [31:0] rs,
                                   input logic tk, output logic [31:0] nxt,
                                   output logic redir, output logic cf);
    logic [5:0] op;
    logic [4:0] rt;
    logic [5:0] fn;
    int         off;
    op = instr[31:26];
    rt = instr[20:16];
    fn = instr[5:0];
    off = $signed(instr[15:0]);
    nxt = fpc + 32'd4;
    redir = 1'b0;
    cf = 1'b0;
    if (op == 6'd4 || (op == 6'd1 && (rt == 5'd17 || rt == 5'd0))) begin
      cf = 1'b1;
      if (tk) begin
        redir = 1'b1;
        nxt = dpc + 32'd4 + 32'(off * 4);
      end
    end else if (op == 6'd2 || op == 6'd3) begin
      cf = 1'b1;
      redir = 1'b1;
      nxt = (dpc & 32'hF000_0000) | ({6'd0, instr[25:0]} * 32'd4);
    end else if (op == 6'd0 && (fn == 6'd8 || fn == 6'd9)) begin
      cf = 1'b1;
      redir = 1'b1;
      nxt = rs;
    end
  endfunction

  logic [31:0] m_pc;
  logic        m_fault;
  logic [31:0] m_br;
  logic [31:0] m_tk;
  logic [31:0] e_nxt;
  logic        e_rd;
  logic        e_cf;

  always_comb ref_next(D_Instr, D_PC, m_pc, D_rs_data, cmp_taken, e_nxt, e_rd, e_cf);

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_pc <= 32'h0000_3000;
      m_fault <= 1'b0;
      m_br <= 32'd0;
      m_tk <= 32'd0;
    end else if (!m_fault && !stall) begin
      if (e_cf) m_br <= m_br + 32'd1;
      if (e_rd) m_tk <= m_tk + 32'd1;
      if (e_nxt[1:0] != 2'b00) m_fault <= 1'b1;
      else m_pc <= e_nxt;
    end
  end

  always @(negedge clk) begin
    chk("cmp_F_PC", F_PC, m_pc);
    chk("cmp_pc_fault", {31'd0, pc_fault}, {31'd0, m_fault});
    chk("cmp_link", D_link_pc, D_PC + 32'd8);
    chk("cmp_redirect", {31'd0, redirect}, {31'd0, (!m_fault && e_rd)});
`ifdef NPC_STATS_EN
    chk("cmp_br_count", br_count, m_br);
    chk("cmp_tk_count", tk_count, m_tk);
`endif
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  localparam logic [31:0] NOP = 32'd0;

  initial begin
    logic [31:0] r;
    logic [31:0] r2;
    int k;

    // 1: reset value and sequential fetch
    #1 reset = 1'b1;
    #2;
    chk("t1_reset_pc", F_PC, 32'h0000_3000);
    chk("t1_reset_fault", {31'd0, pc_fault}, 32'd0);
    tick();
    reset = 1'b0;
    tick(); chk("t1_pc1", F_PC, 32'h0000_3004);
    tick(); chk("t1_pc2", F_PC, 32'h0000_3008);
    tick(); chk("t1_pc3", F_PC, 32'h0000_300C);

    // 2: beq backwards, taken then not taken
    D_PC = 32'h0000_3010;
    D_Instr = {6'd4, 5'd1, 5'd2, 16'hFFFC};
    cmp_taken = 1'b1;
    #2 chk("t2_redirect_taken", {31'd0, redirect}, 32'd1);
    tick(); chk("t2_pc_taken", F_PC, 32'h0000_3004);
    cmp_taken = 1'b0;
    #2 chk("t2_redirect_nt", {31'd0, redirect}, 32'd0);
    tick(); chk("t2_pc_nt", F_PC, 32'h0000_3008);

    // 3: jal with link address
    D_PC = 32'h0000_3020;
    D_Instr = {6'd3, 26'h0000C10};
    #2 chk("t3_link", D_link_pc, 32'h0000_3028);
    tick(); chk("t3_pc", F_PC, 32'h0000_3040);

    // 4: jr to misaligned target, sticky fault, recovery by reset
    D_Instr = {6'd0, 5'd31, 15'd0, 6'b001000};
    D_rs_data = 32'h0000_3006;
    tick();
    chk("t4_fault", {31'd0, pc_fault}, 32'd1);
    chk("t4_pc_hold", F_PC, 32'h0000_3040);
    for (int i = 0; i < 5; i++) begin
      stall = (i % 2 == 1);
      tick();
      chk("t4_pc_frozen", F_PC, 32'h0000_3040);
      chk("t4_no_redirect", {31'd0, redirect}, 32'd0);
    end
    stall = 1'b0;
    reset = 1'b1;
    #2;
    chk("t4_reset_pc", F_PC, 32'h0000_3000);
    chk("t4_reset_fault", {31'd0, pc_fault}, 32'd0);
    tick();
    reset = 1'b0;

    // 5: stalled taken bgezal
    D_PC = 32'h0000_3100;
    D_Instr = {6'd1, 5'd3, 5'b10001, 16'h0004};
    cmp_taken = 1'b1;
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t5_stall_hold", F_PC, 32'h0000_3000);
    end
    stall = 1'b0;
    tick(); chk("t5_target", F_PC, 32'h0000_3114);

    // wrap of PC+4 past the top of the address space
    D_Instr = {6'd0, 5'd4, 15'd0, 6'b001000};
    D_rs_data = 32'hFFFF_FFFC;
    tick(); chk("wrap_top", F_PC, 32'hFFFF_FFFC);
    D_Instr = NOP;
    tick();
    chk("wrap_zero", F_PC, 32'h0000_0000);
    chk("wrap_nofault", {31'd0, pc_fault}, 32'd0);

`ifdef NPC_STATS_EN
    // 6: four resolved branches/jumps, two taken, one stalled repeat
    pulse_reset();
    D_PC = 32'h0000_3000;
    D_Instr = {6'd4, 5'd1, 5'd2, 16'h0000};
    cmp_taken = 1'b1;
    tick();
    stall = 1'b1;
    tick();
    stall = 1'b0;
    cmp_taken = 1'b0;
    tick();
    D_Instr = {6'd2, 26'h0000C00};
    tick();
    D_Instr = {6'd1, 5'd5, 5'b00000, 16'h0010};
    tick();
    D_Instr = NOP;
    chk("t6_br_count", br_count, 32'd4);
    chk("t6_tk_count", tk_count, 32'd2);
`endif

    // randomized phase
    pulse_reset();
    for (int n = 0; n < 3000; n++) begin
      r = $urandom;
      r2 = $urandom;
      k = $urandom_range(0, 8);
      case (k)
        0: D_Instr = {6'd0, r[25:6], 6'h20};
        1: D_Instr = {6'd4, r[25:0]};
        2: D_Instr = {6'd1, r[25:21], 5'b10001, r[15:0]};
        3: D_Instr = {6'd1, r[25:21], 5'b00000, r[15:0]};
        4: D_Instr = {6'd2, r[25:0]};
        5: D_Instr = {6'd3, r[25:0]};
        6: D_Instr = {6'd0, r[25:21], 15'd0, 6'b001000};
        7: D_Instr = {6'd0, r[25:21], 15'd0, 6'b001001};
        default: D_Instr = {6'd8, r[25:0]};
      endcase
      D_PC = ($urandom_range(0, 15) == 0) ? r2 : (r2 & 32'hFFFF_FFFC);
      D_rs_data = ($urandom_range(0, 7) == 0) ? r2 : {r2[31:2], 2'b00};
      cmp_taken = $urandom_range(0, 1) == 1;
      stall = $urandom_range(0, 3) == 0;
      if ($urandom_range(0, 39) == 0) pulse_reset();
      else tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
